// File: rtl/unary_add_n_mod.sv
// unary_add_n_mod
//   Accumulates unary input bits into a modulo-(MAX_CNT+1) counter and then
//   drains the count as a unary output stream.
//   Read  (read_or_write=0): acc += popcount(din), with a carry pulse on wrap.
//   Write (read_or_write=1): one dout=1 per cycle until acc reaches 0, with a
//                            done pulse coinciding with the last dout=1.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   en            in   cycle enable
//   clr           in   synchronous clear (beats en)
//   read_or_write in   0 = accumulate, 1 = drain
//   din           in   NUM_IN unary input bits
//   dout          out  registered unary output stream
//   C             out  registered carry pulse
//   done          out  registered end-of-drain pulse
//   empty         out  combinational, acc == 0
//   carry_cnt     out  saturating carry count (only with UNARY_ADD_CARRY_CNT_EN)
//
// Optional feature macro: UNARY_ADD_CARRY_CNT_EN
module unary_add_n_mod #(
    parameter int NUM_IN  = 2,
    parameter int MAX_CNT = 12,
    parameter int CARRY_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              read_or_write,
    input  logic [NUM_IN-1:0] din,
    output logic              dout,
    output logic              C,
    output logic              done,
`ifdef UNARY_ADD_CARRY_CNT_EN
    output logic              empty,
    output logic [CARRY_W-1:0] carry_cnt
`else
    output logic              empty
`endif
);

    localparam int CW = $clog2(MAX_CNT + 1);
    // Modulus at CW+1 bits so the raw sum and the wrap compare share a width.
    localparam logic [CW:0] MOD = (CW+1)'(MAX_CNT + 1);

    logic [CW-1:0] acc_q, acc_d;
    logic          dout_q, dout_d;
    logic          c_q, c_d;
    logic          done_q, done_d;
    logic [CW:0]   k;
    logic [CW:0]   s;

    always_comb begin
        k = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            k = k + (CW+1)'(din[i]);
        end
        // NUM_IN <= MAX_CNT+1 bounds s below 2*MOD, so one subtract suffices.
        s = {1'b0, acc_q} + k;

        acc_d  = acc_q;
        dout_d = 1'b0;
        c_d    = 1'b0;
        done_d = 1'b0;

        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            if (!read_or_write) begin
                if (s >= MOD) begin
                    acc_d = CW'(s - MOD);
                    c_d   = 1'b1;
                end else begin
                    acc_d = s[CW-1:0];
                end
            end else if (acc_q != '0) begin
                dout_d = 1'b1;
                acc_d  = acc_q - CW'(1);
                // Registered on the 1 -> 0 edge, so it lines up with the last dout.
                done_d = (acc_q == CW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            dout_q <= 1'b0;
            c_q    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            dout_q <= dout_d;
            c_q    <= c_d;
            done_q <= done_d;
        end
    end

    assign dout  = dout_q;
    assign C     = c_q;
    assign done  = done_q;
    assign empty = (acc_q == '0);

`ifdef UNARY_ADD_CARRY_CNT_EN
    logic [CARRY_W-1:0] cc_q;

    // c_d is already forced low by clr or !en; clr never touches the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= '0;
        end else if (c_d && (cc_q != '1)) begin
            cc_q <= cc_q + CARRY_W'(1);
        end
    end

    assign carry_cnt = cc_q;
`endif

endmodule

// File: tb/tb_unary_add_n_mod.sv
// Directed-vector scoreboard bench for unary_add_n_mod.
//   dutA: NUM_IN=2, MAX_CNT=12, CARRY_W=2
//   dutB: NUM_IN=4, MAX_CNT=5
// Stimulus pushes the hand-computed post-edge expectation; the monitor pops
// and compares one entry per clock edge, one time unit after the edge.
module tb_unary_add_n_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_en, a_clr, a_rw;
    logic [1:0] a_din;
    logic       a_dout, a_c, a_done, a_empty;
    logic       b_en, b_clr, b_rw;
    logic [3:0] b_din;
    logic       b_dout, b_c, b_done, b_empty;
`ifdef UNARY_ADD_CARRY_CNT_EN
    logic [1:0] a_cc;
    logic [7:0] b_cc;
`endif

    unary_add_n_mod #(.NUM_IN(2), .MAX_CNT(12), .CARRY_W(2)) dutA (
        .clk(clk), .rst_n(rst_n), .en(a_en), .clr(a_clr), .read_or_write(a_rw),
        .din(a_din), .dout(a_dout), .C(a_c), .done(a_done),
`ifdef UNARY_ADD_CARRY_CNT_EN
        .carry_cnt(a_cc),
`endif
        .empty(a_empty)
    );

    unary_add_n_mod #(.NUM_IN(4), .MAX_CNT(5), .CARRY_W(8)) dutB (
        .clk(clk), .rst_n(rst_n), .en(b_en), .clr(b_clr), .read_or_write(b_rw),
        .din(b_din), .dout(b_dout), .C(b_c), .done(b_done),
`ifdef UNARY_ADD_CARRY_CNT_EN
        .carry_cnt(b_cc),
`endif
        .empty(b_empty)
    );

    typedef struct {
        bit    sel;
        int    acc;
        bit    dout;
        bit    c;
        bit    done;
        int    cc;
        string tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic cyc(input string tag, input bit sel, input bit e, input bit cl,
                       input bit rw, input logic [3:0] d, input int ea,
                       input bit edo, input bit ec, input bit edn, input int ecc = -1);
        exp_t x;
        @(negedge clk);
        a_en = 1'b0; a_clr = 1'b0;
        b_en = 1'b0; b_clr = 1'b0;
        if (!sel) begin
            a_en = e; a_clr = cl; a_rw = rw; a_din = d[1:0];
        end else begin
            b_en = e; b_clr = cl; b_rw = rw; b_din = d;
        end
        x.sel = sel; x.acc = ea; x.dout = edo; x.c = ec; x.done = edn; x.cc = ecc; x.tag = tag;
        q.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            #1;
            n++;
        end
        if (q.size() != 0) chk("scoreboard_timeout", q.size(), 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (!e.sel) begin
                    chk({e.tag, "_acc"},   int'(dutA.acc_q), e.acc);
                    chk({e.tag, "_dout"},  a_dout,  e.dout);
                    chk({e.tag, "_C"},     a_c,     e.c);
                    chk({e.tag, "_done"},  a_done,  e.done);
                    chk({e.tag, "_empty"}, a_empty, e.acc == 0);
`ifdef UNARY_ADD_CARRY_CNT_EN
                    if (e.cc >= 0) chk({e.tag, "_carry_cnt"}, a_cc, e.cc);
`endif
                end else begin
                    chk({e.tag, "_acc"},   int'(dutB.acc_q), e.acc);
                    chk({e.tag, "_dout"},  b_dout,  e.dout);
                    chk({e.tag, "_C"},     b_c,     e.c);
                    chk({e.tag, "_done"},  b_done,  e.done);
                    chk({e.tag, "_empty"}, b_empty, e.acc == 0);
                end
            end
        end
    end

    initial begin
        int carries;
        int ea;
        rst_n = 1'b0;
        a_en = 0; a_clr = 0; a_rw = 0; a_din = '0;
        b_en = 0; b_clr = 0; b_rw = 0; b_din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_a_dout", a_dout, 0);  chk("rst_a_C", a_c, 0);
        chk("rst_a_done", a_done, 0);  chk("rst_a_empty", a_empty, 1);
        chk("rst_b_dout", b_dout, 0);  chk("rst_b_empty", b_empty, 1);

        // Accumulate 2 per cycle to 12, then +1 wraps to 0 with a carry.
        for (int i = 1; i <= 6; i++) cyc("acc_by2", 0, 1, 0, 0, 4'b0011, 2*i, 0, 0, 0);
        cyc("wrap_13", 0, 1, 0, 0, 4'b0001, 0, 0, 1, 0);
        cyc("din_zero", 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0);

        // Wrap by two from 11 and from 12.
        for (int i = 1; i <= 5; i++) cyc("to11", 0, 1, 0, 0, 4'b0011, 2*i, 0, 0, 0);
        cyc("to11", 0, 1, 0, 0, 4'b0001, 11, 0, 0, 0);
        cyc("wrap_11p2", 0, 1, 0, 0, 4'b0011, 0, 0, 1, 0);
        for (int i = 1; i <= 6; i++) cyc("to12", 0, 1, 0, 0, 4'b0011, 2*i, 0, 0, 0);
        cyc("wrap_12p2", 0, 1, 0, 0, 4'b0011, 1, 0, 1, 0);

        // Drain 5 over 8 write cycles; din is ignored in write.
        cyc("to5", 0, 1, 0, 0, 4'b0011, 3, 0, 0, 0);
        cyc("to5", 0, 1, 0, 0, 4'b0011, 5, 0, 0, 0);
        for (int i = 1; i <= 5; i++) cyc("drain5", 0, 1, 0, 1, 4'b0011, 5 - i, 1, 0, i == 5);
        for (int i = 0; i < 3; i++) cyc("drain5_tail", 0, 1, 0, 1, 4'b0011, 0, 0, 0, 0);

        // Drain of 4 paused for two cycles.
        cyc("to4", 0, 1, 0, 0, 4'b0011, 2, 0, 0, 0);
        cyc("to4", 0, 1, 0, 0, 4'b0011, 4, 0, 0, 0);
        cyc("drain4", 0, 1, 0, 1, 4'b0000, 3, 1, 0, 0);
        cyc("drain4", 0, 1, 0, 1, 4'b0000, 2, 1, 0, 0);
        cyc("pause", 0, 0, 0, 1, 4'b0000, 2, 0, 0, 0);
        cyc("pause", 0, 0, 0, 1, 4'b0000, 2, 0, 0, 0);
        cyc("resume", 0, 1, 0, 1, 4'b0000, 1, 1, 0, 0);
        cyc("resume", 0, 1, 0, 1, 4'b0000, 0, 1, 0, 1);
        cyc("write_at0", 0, 1, 0, 1, 4'b0000, 0, 0, 0, 0);

        // Hold with en low in read, then clear at 12 with a would-be carry.
        cyc("hold_pre", 0, 1, 0, 0, 4'b0011, 2, 0, 0, 0);
        cyc("hold", 0, 0, 0, 0, 4'b0011, 2, 0, 0, 0);
        for (int i = 2; i <= 6; i++) cyc("to12b", 0, 1, 0, 0, 4'b0011, 2*i, 0, 0, 0);
        cyc("clr", 0, 1, 1, 0, 4'b0011, 0, 0, 0, 0);
        cyc("post_clr", 0, 1, 0, 0, 4'b0001, 1, 0, 0, 0);

        // Second parameter set: NUM_IN=4, MAX_CNT=5.
        cyc("b_read", 1, 1, 0, 0, 4'b0011, 2, 0, 0, 0);
        cyc("b_read", 1, 1, 0, 0, 4'b0001, 3, 0, 0, 0);
        cyc("b_wrap4", 1, 1, 0, 0, 4'b1111, 1, 0, 1, 0);
        cyc("b_read", 1, 1, 0, 0, 4'b0101, 3, 0, 0, 0);
        cyc("b_drain", 1, 1, 0, 1, 4'b0000, 2, 1, 0, 0);
        cyc("b_drain", 1, 1, 0, 1, 4'b0000, 1, 1, 0, 0);
        drain();

        // Asynchronous reset between edges, mid-drain.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_b_dout", b_dout, 0);  chk("arst_b_C", b_c, 0);
        chk("arst_b_done", b_done, 0);  chk("arst_b_empty", b_empty, 1);
        chk("arst_b_acc", int'(dutB.acc_q), 0);
        chk("arst_a_empty", a_empty, 1);
`ifdef UNARY_ADD_CARRY_CNT_EN
        chk("arst_a_carry_cnt", a_cc, 0);
        chk("arst_b_carry_cnt", b_cc, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cyc("b_post_rst_idle", 1, 0, 0, 1, 4'b0000, 0, 0, 0, 0);
        cyc("b_post_rst_read", 1, 1, 0, 0, 4'b0011, 2, 0, 0, 0);

        // Five carries on dutA: acc steps by 2 mod 13, count saturates at 3.
        carries = 0;
        for (int n = 1; n <= 33; n++) begin
            ea = (2 * n) % 13;
            if (ea < 2) carries++;
            cyc("carry_cnt", 0, 1, 0, 0, 4'b0011, ea, 0, ea < 2, 0,
                (carries > 3) ? 3 : carries);
        end
        cyc("clr_keeps_cnt", 0, 1, 1, 0, 4'b0011, 0, 0, 0, 0, 3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
